// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the memory stage,
// the unified memory port and the port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              stall_if;
  logic              stall_mem;
  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  stall_if, stall_mem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch vs data with data priority
// and a starvation counter that guarantees fetch progress.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    RESP
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t            state, state_n;
  logic [3:0]        starve_cnt, starve_n;
  logic              req_q, req_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] if_rd_q, if_rd_n;
  logic [DATA_W-1:0] dm_rd_q, dm_rd_n;
  logic              if_ack_q, if_ack_n;
  logic              dm_ack_q, dm_ack_n;
  logic              pick_dm, pick_if;
  logic [3:0]        starve_inc;

  // Fetch wins only once it has been passed over STARVE_MAX times.
  assign pick_dm = bus.dm_req &
                   ~(bus.if_req & (starve_cnt == SMAX));
  assign pick_if = bus.if_req & ~pick_dm;

  assign starve_inc = (starve_cnt == SMAX) ? SMAX
                                           : starve_cnt + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rd_q    <= '0;
      dm_rd_q    <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      req_q      <= req_n;
      we_q       <= we_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      if_rd_q    <= if_rd_n;
      dm_rd_q    <= dm_rd_n;
      if_ack_q   <= if_ack_n;
      dm_ack_q   <= dm_ack_n;
    end
  end

  always_comb begin
    state_n  = state;
    starve_n = starve_cnt;
    req_n    = req_q;
    we_n     = we_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    if_rd_n  = if_rd_q;
    dm_rd_n  = dm_rd_q;
    if_ack_n = 1'b0;
    dm_ack_n = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          pick_dm: begin
            state_n  = BUSY_DM;
            req_n    = 1'b1;
            we_n     = bus.dm_we;
            addr_n   = bus.dm_addr;
            wdata_n  = bus.dm_wdata;
            starve_n = bus.if_req ? starve_inc : 4'd0;
          end
          pick_if: begin
            state_n  = BUSY_IF;
            req_n    = 1'b1;
            we_n     = 1'b0;
            addr_n   = bus.if_addr;
            starve_n = 4'd0;
          end
          default: ;
        endcase
      end
      BUSY_IF: begin
        if (bus.mem_ready) begin
          state_n  = RESP;
          req_n    = 1'b0;
          if_ack_n = 1'b1;
          if_rd_n  = bus.mem_rdata;
        end
      end
      BUSY_DM: begin
        if (bus.mem_ready) begin
          state_n  = RESP;
          req_n    = 1'b0;
          dm_ack_n = 1'b1;
          if (!we_q) dm_rd_n = bus.mem_rdata;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rd_q;
  assign bus.dm_rdata  = dm_rd_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.dm_req & ~dm_ack_q;
  assign bus.busy      = (state != IDLE);

endmodule
